sensor_conditioner: RTL and testbench

- Front-end conditioner for the two reed-switch inputs, fork and crank, in the cycle computer.
- Sits between the pads and the sensor manager.
- Per channel it synchronises the raw active-low input, debounces it, and enforces a minimum re-trigger interval.
- Outputs: a clean active-low level for the sensor manager's nFork/nCrank inputs, a one-cycle event strobe, and a saturating glitch counter for diagnostics.

---
 rtl/sensor_conditioner_if.sv | 23 ++
 rtl/sensor_conditioner.sv | 154 +++++++++++++++
 tb/tb_sensor_conditioner.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/sensor_conditioner_if.sv
// Pad-side and sensor-manager-side signals of the fork/crank reed-switch conditioner.
// The conditioner binds to the slave modport; the pad/manager side binds to master.
interface sensor_conditioner_if;
    logic       nFork_raw;
    logic       nCrank_raw;
    logic       glitch_clr;
    logic       nFork;
    logic       nCrank;
    logic       fork_evt;
    logic       crank_evt;
    logic [7:0] fork_glitch;
    logic [7:0] crank_glitch;

    modport master (
        output nFork_raw, nCrank_raw, glitch_clr,
        input  nFork, nCrank, fork_evt, crank_evt, fork_glitch, crank_glitch
    );

    modport slave (
        input  nFork_raw, nCrank_raw, glitch_clr,
        output nFork, nCrank, fork_evt, crank_evt, fork_glitch, crank_glitch
    );
endinterface

// File: rtl/sensor_conditioner.sv
// Two-channel reed-switch conditioner: synchronise, debounce and rate-limit each
// active-low input, producing a clean level, a press strobe and a glitch count.
module sensor_conditioner #(
    parameter int unsigned FILTER_CYCLES = 32,
    parameter int unsigned MIN_PERIOD    = 1024
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    sensor_conditioner_if.slave  bus
);
    localparam int unsigned NCH    = 2;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned LOCK_W = 16;
    localparam int unsigned GL_W   = 8;

    localparam logic [CNT_W-1:0]  FILT_MAX  = CNT_W'(FILTER_CYCLES);
    localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(MIN_PERIOD);
    localparam logic [GL_W-1:0]   GL_MAX    = '1;

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        PRESS_CHK   = 2'd1,
        PRESSED     = 2'd2,
        RELEASE_CHK = 2'd3
    } state_t;

    // Channel 0 = fork, channel 1 = crank
    logic [NCH-1:0] w_raw;
    assign w_raw = {bus.nCrank_raw, bus.nFork_raw};

    logic [NCH-1:0]    r_sync1;
    logic [NCH-1:0]    r_sync2;
    state_t            r_state     [NCH];
    state_t            w_state_nxt [NCH];
    logic [CNT_W-1:0]  r_cnt       [NCH];
    logic [CNT_W-1:0]  w_cnt_nxt   [NCH];
    logic [LOCK_W-1:0] r_lock      [NCH];
    logic [LOCK_W-1:0] w_lock_nxt  [NCH];
    logic [GL_W-1:0]   r_glitch    [NCH];
    logic [GL_W-1:0]   w_glitch_nxt[NCH];
    logic [NCH-1:0]    r_reject;
    logic [NCH-1:0]    w_reject_nxt;
    logic [NCH-1:0]    r_clean;
    logic [NCH-1:0]    w_clean_nxt;
    logic [NCH-1:0]    r_evt;
    logic [NCH-1:0]    w_evt_nxt;
    logic [NCH-1:0]    w_glitch_inc;

    // State and datapath registers; reset aborts every channel on the same edge
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_sync1  <= '1;
            r_sync2  <= '1;
            r_reject <= '0;
            r_clean  <= '1;
            r_evt    <= '0;
            for (int ch = 0; ch < NCH; ch++) begin
                r_state[ch]  <= RELEASED;
                r_cnt[ch]    <= '0;
                r_lock[ch]   <= '0;
                r_glitch[ch] <= '0;
            end
        end else begin
            r_sync1  <= w_raw;
            r_sync2  <= r_sync1;
            r_reject <= w_reject_nxt;
            r_clean  <= w_clean_nxt;
            r_evt    <= w_evt_nxt;
            for (int ch = 0; ch < NCH; ch++) begin
                r_state[ch]  <= w_state_nxt[ch];
                r_cnt[ch]    <= w_cnt_nxt[ch];
                r_lock[ch]   <= w_lock_nxt[ch];
                r_glitch[ch] <= w_glitch_nxt[ch];
            end
        end
    end

    // Per-channel debounce FSM, lockout and glitch bookkeeping
    always_comb begin
        for (int ch = 0; ch < NCH; ch++) begin
            w_state_nxt[ch]  = r_state[ch];
            w_cnt_nxt[ch]    = r_cnt[ch];
            w_lock_nxt[ch]   = (r_lock[ch] != '0) ? r_lock[ch] - LOCK_W'(1) : r_lock[ch];
            w_reject_nxt[ch] = r_reject[ch] & ~r_sync2[ch];
            w_evt_nxt[ch]    = 1'b0;
            w_glitch_inc[ch] = 1'b0;

            case (r_state[ch])
                RELEASED: begin
                    if (!r_sync2[ch]) begin
                        if (r_reject[ch]) begin
                            w_state_nxt[ch] = RELEASED;
                        end else if (r_lock[ch] == '0) begin
                            w_state_nxt[ch] = PRESS_CHK;
                            w_cnt_nxt[ch]   = CNT_W'(1);
                        end else begin
                            w_reject_nxt[ch] = 1'b1;
                            w_glitch_inc[ch] = 1'b1;
                        end
                    end
                end
                PRESS_CHK: begin
                    if (r_cnt[ch] == FILT_MAX) begin
                        w_state_nxt[ch] = PRESSED;
                        w_evt_nxt[ch]   = 1'b1;
                        w_lock_nxt[ch]  = LOCK_LOAD;
                    end else if (r_sync2[ch]) begin
                        w_state_nxt[ch]  = RELEASED;
                        w_glitch_inc[ch] = 1'b1;
                    end else begin
                        w_cnt_nxt[ch] = r_cnt[ch] + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (r_sync2[ch]) begin
                        w_state_nxt[ch] = RELEASE_CHK;
                        w_cnt_nxt[ch]   = CNT_W'(1);
                    end
                end
                RELEASE_CHK: begin
                    if (r_cnt[ch] == FILT_MAX) begin
                        w_state_nxt[ch] = RELEASED;
                    end else if (!r_sync2[ch]) begin
                        w_state_nxt[ch]  = PRESSED;
                        w_glitch_inc[ch] = 1'b1;
                    end else begin
                        w_cnt_nxt[ch] = r_cnt[ch] + CNT_W'(1);
                    end
                end
                default: w_state_nxt[ch] = RELEASED;
            endcase

            w_clean_nxt[ch] = !((w_state_nxt[ch] == PRESSED) ||
                                (w_state_nxt[ch] == RELEASE_CHK));

            // Clear beats a same-cycle increment; count saturates at all-ones
            if (bus.glitch_clr) begin
                w_glitch_nxt[ch] = '0;
            end else if (w_glitch_inc[ch] && (r_glitch[ch] != GL_MAX)) begin
                w_glitch_nxt[ch] = r_glitch[ch] + GL_W'(1);
            end else begin
                w_glitch_nxt[ch] = r_glitch[ch];
            end
        end
    end

    assign bus.nFork        = r_clean[0];
    assign bus.nCrank       = r_clean[1];
    assign bus.fork_evt     = r_evt[0];
    assign bus.crank_evt    = r_evt[1];
    assign bus.fork_glitch  = r_glitch[0];
    assign bus.crank_glitch = r_glitch[1];

endmodule

// File: tb/tb_sensor_conditioner.sv
// Directed bench for sensor_conditioner with FILTER_CYCLES=4, MIN_PERIOD=16.
// Edge 0 is the first rising edge that samples a newly driven raw level.
module tb_sensor_conditioner;
    logic HCLK;
    logic HRESETn;
    int   total;
    int   passed;
    int   evt_seen;

    sensor_conditioner_if bus ();

    sensor_conditioner #(
        .FILTER_CYCLES(4),
        .MIN_PERIOD   (16)
    ) dut (
        .HCLK   (HCLK),
        .HRESETn(HRESETn),
        .bus    (bus)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge HCLK);
            #1;
        end
    endtask

    // Step n cycles, counting fork_evt pulses seen
    task automatic step_count_fork(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge HCLK);
            #1;
            if (bus.fork_evt === 1'b1) evt_seen++;
        end
    endtask

    task automatic test_reset();
        HRESETn = 1'b0;
        bus.nFork_raw = 1'b1;
        bus.nCrank_raw = 1'b1;
        bus.glitch_clr = 1'b0;
        step(3);
        HRESETn = 1'b1;
        step(10);
        total++; if (bus.nFork !== 1'b1) $display("FAIL reset_nFork: got %b want 1", bus.nFork); else passed++;
        total++; if (bus.nCrank !== 1'b1) $display("FAIL reset_nCrank: got %b want 1", bus.nCrank); else passed++;
        total++; if (bus.fork_evt !== 1'b0) $display("FAIL reset_fork_evt: got %b want 0", bus.fork_evt); else passed++;
        total++; if (bus.crank_evt !== 1'b0) $display("FAIL reset_crank_evt: got %b want 0", bus.crank_evt); else passed++;
        total++; if (bus.fork_glitch !== 8'd0) $display("FAIL reset_fork_glitch: got %0d want 0", bus.fork_glitch); else passed++;
        total++; if (bus.crank_glitch !== 8'd0) $display("FAIL reset_crank_glitch: got %0d want 0", bus.crank_glitch); else passed++;
    endtask

    task automatic test_press_release();
        bus.nFork_raw = 1'b0;
        step(6);  // after edge 5
        total++; if (bus.nFork !== 1'b1) $display("FAIL press_nFork_e5: got %b want 1", bus.nFork); else passed++;
        total++; if (bus.fork_evt !== 1'b0) $display("FAIL press_evt_e5: got %b want 0", bus.fork_evt); else passed++;
        step(1);  // after edge 6
        total++; if (bus.nFork !== 1'b0) $display("FAIL press_nFork_e6: got %b want 0", bus.nFork); else passed++;
        total++; if (bus.fork_evt !== 1'b1) $display("FAIL press_evt_e6: got %b want 1", bus.fork_evt); else passed++;
        evt_seen = 0;
        step_count_fork(23);  // after edge 29
        total++; if (evt_seen !== 0) $display("FAIL press_evt_single: got %0d extra pulses want 0", evt_seen); else passed++;
        bus.nFork_raw = 1'b1;  // sampled at edge 30
        step(6);  // after edge 35
        total++; if (bus.nFork !== 1'b0) $display("FAIL release_nFork_e35: got %b want 0", bus.nFork); else passed++;
        step(1);  // after edge 36
        total++; if (bus.nFork !== 1'b1) $display("FAIL release_nFork_e36: got %b want 1", bus.nFork); else passed++;
        total++; if (bus.fork_glitch !== 8'd0) $display("FAIL release_glitch: got %0d want 0", bus.fork_glitch); else passed++;
        step(20);
    endtask

    task automatic test_glitch_saturate();
        evt_seen = 0;
        bus.nFork_raw = 1'b0;
        step_count_fork(2);
        bus.nFork_raw = 1'b1;
        step_count_fork(3);
        total++; if (bus.fork_glitch !== 8'd1) $display("FAIL glitch_one: got %0d want 1", bus.fork_glitch); else passed++;
        total++; if (bus.nFork !== 1'b1) $display("FAIL glitch_nFork: got %b want 1", bus.nFork); else passed++;
        for (int p = 0; p < 300; p++) begin
            bus.nFork_raw = 1'b0;
            step_count_fork(2);
            bus.nFork_raw = 1'b1;
            step_count_fork(3);
        end
        total++; if (bus.fork_glitch !== 8'd255) $display("FAIL glitch_saturate: got %0d want 255", bus.fork_glitch); else passed++;
        total++; if (evt_seen !== 0) $display("FAIL glitch_no_evt: got %0d pulses want 0", evt_seen); else passed++;
        total++; if (bus.nFork !== 1'b1) $display("FAIL glitch_nFork_end: got %b want 1", bus.nFork); else passed++;
    endtask

    task automatic test_lockout();
        bus.glitch_clr = 1'b1;
        step(1);
        bus.glitch_clr = 1'b0;
        total++; if (bus.fork_glitch !== 8'd0) $display("FAIL lock_clear: got %0d want 0", bus.fork_glitch); else passed++;
        step(5);
        bus.nFork_raw = 1'b0;
        step(7);  // after edge 6
        total++; if (bus.fork_evt !== 1'b1) $display("FAIL lock_first_evt: got %b want 1", bus.fork_evt); else passed++;
        bus.nFork_raw = 1'b1;
        step(9);  // after edge 15
        evt_seen = 0;
        bus.nFork_raw = 1'b0;  // evt + 10, lockout still running
        step_count_fork(2);
        bus.nFork_raw = 1'b1;
        step_count_fork(4);  // after edge 21
        total++; if (bus.fork_glitch !== 8'd1) $display("FAIL lock_reject_glitch: got %0d want 1", bus.fork_glitch); else passed++;
        total++; if (evt_seen !== 0) $display("FAIL lock_reject_evt: got %0d pulses want 0", evt_seen); else passed++;
        total++; if (bus.nFork !== 1'b1) $display("FAIL lock_reject_nFork: got %b want 1", bus.nFork); else passed++;
        step(4);  // after edge 25
        bus.nFork_raw = 1'b0;  // evt + 20, lockout expired
        step(6);  // after edge 31
        total++; if (bus.fork_evt !== 1'b0) $display("FAIL lock_second_evt_early: got %b want 0", bus.fork_evt); else passed++;
        step(1);  // after edge 32
        total++; if (bus.fork_evt !== 1'b1) $display("FAIL lock_second_evt: got %b want 1", bus.fork_evt); else passed++;
        total++; if (bus.fork_glitch !== 8'd1) $display("FAIL lock_second_glitch: got %0d want 1", bus.fork_glitch); else passed++;
        bus.nFork_raw = 1'b1;
        step(30);
    endtask

    task automatic test_both_and_clear();
        bus.nFork_raw = 1'b0;
        bus.nCrank_raw = 1'b0;
        step(6);  // after edge 5
        total++; if ({bus.fork_evt, bus.crank_evt} !== 2'b00) $display("FAIL both_evt_e5: got %b want 00", {bus.fork_evt, bus.crank_evt}); else passed++;
        step(1);  // after edge 6
        total++; if ({bus.fork_evt, bus.crank_evt} !== 2'b11) $display("FAIL both_evt_e6: got %b want 11", {bus.fork_evt, bus.crank_evt}); else passed++;
        total++; if ({bus.nFork, bus.nCrank} !== 2'b00) $display("FAIL both_level_e6: got %b want 00", {bus.nFork, bus.nCrank}); else passed++;
        bus.nFork_raw = 1'b1;
        bus.nCrank_raw = 1'b1;
        step(30);
        bus.nCrank_raw = 1'b0;
        step(2);
        bus.nCrank_raw = 1'b1;
        step(3);
        total++; if (bus.crank_glitch !== 8'd1) $display("FAIL crank_glitch_one: got %0d want 1", bus.crank_glitch); else passed++;
        step(3);
        bus.nCrank_raw = 1'b0;
        step(2);  // edges 0,1
        bus.nCrank_raw = 1'b1;
        step(2);  // edges 2,3
        bus.glitch_clr = 1'b1;
        step(1);  // edge 4: increment and clear together
        bus.glitch_clr = 1'b0;
        total++; if (bus.crank_glitch !== 8'd0) $display("FAIL clear_priority_crank: got %0d want 0", bus.crank_glitch); else passed++;
        total++; if (bus.fork_glitch !== 8'd0) $display("FAIL clear_fork: got %0d want 0", bus.fork_glitch); else passed++;
        step(20);
    endtask

    task automatic test_mid_reset();
        bus.nFork_raw = 1'b0;
        step(5);  // after edge 4, filter count 3
        HRESETn = 1'b0;
        step(1);  // edge 5
        HRESETn = 1'b1;
        total++; if (bus.nFork !== 1'b1) $display("FAIL midrst_nFork: got %b want 1", bus.nFork); else passed++;
        total++; if (bus.fork_evt !== 1'b0) $display("FAIL midrst_evt: got %b want 0", bus.fork_evt); else passed++;
        total++; if (bus.fork_glitch !== 8'd0) $display("FAIL midrst_glitch: got %0d want 0", bus.fork_glitch); else passed++;
        step(6);  // after edge 11
        total++; if (bus.nFork !== 1'b1) $display("FAIL midrst_requal_e11: got %b want 1", bus.nFork); else passed++;
        step(1);  // after edge 12
        total++; if (bus.fork_evt !== 1'b1) $display("FAIL midrst_requal_evt: got %b want 1", bus.fork_evt); else passed++;
        total++; if (bus.nFork !== 1'b0) $display("FAIL midrst_requal_nFork: got %b want 0", bus.nFork); else passed++;
        bus.nFork_raw = 1'b1;
        step(10);
    endtask

    initial begin
        total = 0;
        passed = 0;
        evt_seen = 0;
        test_reset();
        test_press_release();
        test_glitch_saturate();
        test_lockout();
        test_both_and_clear();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
